// File: rtl/gate_truth_checker_if.sv
// Handshake/result bundle between the gate-bank self-test engine and its host.
// Carries start, gate-bank observations, drive outputs and run results.
interface gate_truth_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic [6:0]       gate_in;
    logic             a_drv;
    logic             b_drv;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       fail_vec;
    logic [1:0]       fail_idx;

    modport master (
        output start, gate_in,
        input  a_drv, b_drv, busy, done, pass, err_count, fail_vec, fail_idx
    );

    modport slave (
        input  start, gate_in,
        output a_drv, b_drv, busy, done, pass, err_count, fail_vec, fail_idx
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Self-test engine for the two-input gate bank: sweeps {a,b} = 00..11 for
// PASSES sweeps, waits SETTLE_CYCLES per vector, then checks the seven gate
// outputs against the truth table.
// Ports: clk, rst_n (sync, active-low), bus (slave modport): start, gate_in
// in; a_drv, b_drv, busy, done, pass, err_count, fail_vec, fail_idx out.
// Optional feature: GATE_CHECK_STOP_ON_FAIL_EN ends the run on the first
// mismatching sample.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_truth_checker_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [CW-1:0]    CNT_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [6:0]       fv_q, fv_d;
    logic [1:0]       fidx_q, fidx_d;

    logic [6:0] expected;
    logic [6:0] mismatch;
    logic       stop;

    always_comb begin
        // bit order: xnor, xor, nor, nand, not(a), or, and
        expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q),
                    ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
        mismatch = bus.gate_in ^ expected;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        stop = |mismatch;
`else
        stop = 1'b0;
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        a_d     = a_q;
        b_d     = b_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fidx_d  = fidx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = '0;
                    fidx_d  = '0;
                    idx_d   = 2'd0;
                    pcnt_d  = '0;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                fv_d = fv_q | mismatch;
                if (mismatch != 7'd0) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    // err_q only leaves zero on the first failing sample
                    if (err_q == '0) begin
                        fidx_d = {a_q, b_q};
                    end
                end
                cnt_d = '0;
                if (!stop && idx_q != 2'd3) begin
                    idx_d            = idx_q + 2'd1;
                    {a_d, b_d}       = idx_q + 2'd1;
                    state_d          = ST_SETTLE;
                end else if (!stop && pcnt_q != PASS_LAST) begin
                    idx_d            = 2'd0;
                    {a_d, b_d}       = 2'b00;
                    pcnt_d           = pcnt_q + 1'b1;
                    state_d          = ST_SETTLE;
                end else begin
                    {a_d, b_d}       = 2'b00;
                    pass_d           = (err_d == '0);
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pcnt_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= '0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fidx_q  <= fidx_d;
        end
    end

    assign bus.a_drv     = a_q;
    assign bus.b_drv     = b_q;
    assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fv_q;
    assign bus.fail_idx  = fidx_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized self-checking bench for gate_truth_checker: two instances
// (defaults, and SETTLE=1/PASSES=4/ERR_W=2) against a timeline model.
module tb_gate_truth_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    gate_truth_checker_if #(.ERR_W(8)) if0 ();
    gate_truth_checker_if #(.ERR_W(2)) if1 ();

    // truth table per vector {a,b}, bits [6:0] = xnor,xor,nor,nand,not,or,and
    logic [6:0] tt [4] = '{7'b1011100, 7'b0101110, 7'b0101010, 7'b1000011};
    logic [6:0] inv [2];
    logic [6:0] stk [2];

    assign if0.gate_in = (tt[{if0.a_drv, if0.b_drv}] & ~stk[0]) ^ inv[0];
    assign if1.gate_in = (tt[{if1.a_drv, if1.b_drv}] & ~stk[1]) ^ inv[1];

    gate_truth_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    gate_truth_checker #(.SETTLE_CYCLES(1), .PASSES(4), .ERR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    int sc [2] = '{2, 1};
    int pc [2] = '{1, 4};
    int emax [2] = '{255, 3};

    bit seen [2];
    int t [2];
    int nv [2];
    logic [6:0] mm [2][16];

    int total = 0;
    int bad = 0;
    int rt, d0, d1;

    function automatic int nrun(int i);
        return nv[i] * (sc[i] + 1);
    endfunction

    function automatic bit idle(int i);
        return !seen[i] || t[i] >= nrun(i) + 2;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(int i, logic st, logic rn);
        if (!rn) begin
            seen[i] = 1'b0;
        end else if (idle(i) && st) begin
            seen[i] = 1'b1;
            t[i] = 1;
            nv[i] = 4 * pc[i];
            for (int k = 0; k < 4 * pc[i]; k++) begin
                mm[i][k] = ((tt[k % 4] & ~stk[i]) ^ inv[i]) ^ tt[k % 4];
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                if (mm[i][k] != 7'd0 && nv[i] == 4 * pc[i]) nv[i] = k + 1;
`endif
            end
        end else if (seen[i] && t[i] < 100000) begin
            t[i]++;
        end
    endtask

    task automatic cmp_inst(int i, logic bz, logic dn, logic a, logic b,
                            logic ps, logic [31:0] er, logic [6:0] fv,
                            logic [1:0] fi);
        int s1, n, cnt, eb, ed, eab, ep, ee;
        logic [6:0] efv;
        logic [1:0] efi;
        eb = 0; ed = 0; eab = 0; ep = 0; ee = 0; efv = '0; efi = '0;
        if (seen[i]) begin
            s1 = sc[i] + 1;
            n = nrun(i);
            cnt = 0;
            for (int k = 0; k < nv[i]; k++) begin
                if ((k + 1) * s1 <= t[i] - 1 && mm[i][k] != 7'd0) begin
                    if (cnt == 0) efi = 2'(k % 4);
                    cnt++;
                    efv |= mm[i][k];
                end
            end
            eb  = (t[i] <= n) ? 1 : 0;
            ed  = (t[i] == n + 1) ? 1 : 0;
            eab = (t[i] <= n) ? ((t[i] - 1) / s1) % 4 : 0;
            ep  = (t[i] > n && cnt == 0) ? 1 : 0;
            ee  = (cnt > emax[i]) ? emax[i] : cnt;
        end
        check($sformatf("u%0d_busy", i), 32'(bz), 32'(eb));
        check($sformatf("u%0d_done", i), 32'(dn), 32'(ed));
        check($sformatf("u%0d_ab", i), 32'({a, b}), 32'(eab));
        check($sformatf("u%0d_pass", i), 32'(ps), 32'(ep));
        check($sformatf("u%0d_err", i), er, 32'(ee));
        check($sformatf("u%0d_fvec", i), 32'(fv), 32'(efv));
        check($sformatf("u%0d_fidx", i), 32'(fi), 32'(efi));
    endtask

    task automatic tick(logic st, logic rn);
        if0.start = st;
        if1.start = st;
        rst_n = rn;
        model_edge(0, st, rn);
        model_edge(1, st, rn);
        rt++;
        @(negedge clk);
        cmp_inst(0, if0.busy, if0.done, if0.a_drv, if0.b_drv, if0.pass,
                 32'(if0.err_count), if0.fail_vec, if0.fail_idx);
        cmp_inst(1, if1.busy, if1.done, if1.a_drv, if1.b_drv, if1.pass,
                 32'(if1.err_count), if1.fail_vec, if1.fail_idx);
        if (if0.done === 1'b1 && d0 == 0) d0 = rt;
        if (if1.done === 1'b1 && d1 == 0) d1 = rt;
    endtask

    task automatic newrun();
        rt = 0; d0 = 0; d1 = 0;
    endtask

    task automatic drain();
        for (int j = 0; j < 80 && !(idle(0) && idle(1)); j++) tick(1'b0, 1'b1);
        check("drain_idle", 32'(idle(0) && idle(1)), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        inv[0] = '0; inv[1] = '0; stk[0] = '0; stk[1] = '0;
        seen[0] = 1'b0; seen[1] = 1'b0;
        t[0] = 0; t[1] = 0; nv[0] = 4; nv[1] = 16;
        newrun();
        @(negedge clk);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // correct bank
        newrun();
        tick(1'b1, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        check("p1_done_at0", 32'(d0), 32'd13);
        check("p1_done_at1", 32'(d1), 32'd33);
        check("p1_pass0", 32'(if0.pass), 32'd1);
        check("p1_err0", 32'(if0.err_count), 32'd0);
        check("p1_fvec0", 32'(if0.fail_vec), 32'd0);

        // xor stuck at 0 on unit 0, all outputs inverted on unit 1
        stk[0] = 7'b0100000;
        inv[1] = 7'h7F;
        newrun();
        tick(1'b1, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        check("p2_model_mm1", 32'(mm[0][1]), 32'h20);
        check("p2_fvec0", 32'(if0.fail_vec), 32'h20);
        check("p2_fidx0", 32'(if0.fail_idx), 32'd1);
        check("p2_pass0", 32'(if0.pass), 32'd0);
        check("p2_fvec1", 32'(if1.fail_vec), 32'h7F);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        check("p2_err0", 32'(if0.err_count), 32'd1);
        check("p2_done_at0", 32'(d0), 32'd7);
        check("p2_err1", 32'(if1.err_count), 32'd1);
        check("p2_done_at1", 32'(d1), 32'd3);
`else
        check("p2_err0", 32'(if0.err_count), 32'd2);
        check("p2_err1_sat", 32'(if1.err_count), 32'd3);
        check("p2_done_at1", 32'(d1), 32'd33);
`endif

        // reset at E5 aborts, then a clean run
        stk[0] = '0;
        inv[1] = '0;
        newrun();
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("p3_rst_busy0", 32'(if0.busy), 32'd0);
        check("p3_rst_ab0", 32'({if0.a_drv, if0.b_drv}), 32'd0);
        repeat (20) tick(1'b0, 1'b1);
        check("p3_no_done0", 32'(d0), 32'd0);
        check("p3_no_done1", 32'(d1), 32'd0);
        newrun();
        tick(1'b1, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        check("p3_done_at0", 32'(d0), 32'd13);
        check("p3_pass0", 32'(if0.pass), 32'd1);

        // start at E4 is ignored
        stk[0] = 7'b0100000;
        newrun();
        tick(1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        check("p4_fidx0", 32'(if0.fail_idx), 32'd1);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        check("p4_done_at0", 32'(d0), 32'd7);
        check("p4_err0", 32'(if0.err_count), 32'd1);
`else
        check("p4_done_at0", 32'(d0), 32'd13);
        check("p4_err0", 32'(if0.err_count), 32'd2);
`endif

        // randomized faults, start gaps, stray starts and resets
        for (int r = 0; r < 24; r++) begin
            drain();
            for (int i = 0; i < 2; i++) begin
                inv[i] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
                stk[i] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            end
            newrun();
            repeat ($urandom_range(0, 3)) tick(1'b0, 1'b1);
            tick(1'b1, 1'b1);
            for (int j = 0; j < int'($urandom_range(5, 45)); j++) begin
                tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 40) != 0));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
